// File: rtl/battleship_shot_ctrl.sv
// Sequential front end for the Battleship scoring block: accepts shot requests,
// filters illegal/repeat shots against a 10x10 history, and tracks game progress.
module battleship_shot_ctrl #(
    parameter int MAX_SHOTS        = 50,
    parameter int TOTAL_SHIP_CELLS = 17,
    parameter int BIG_SHOTS        = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       new_game,
    input  logic       shot_valid,
    output logic       shot_ready,
    input  logic [3:0] shot_x,
    input  logic [3:0] shot_y,
    input  logic       shot_big,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic       Big,
    output logic [1:0] BigLeft,
    output logic       ScoreThis,
    input  logic       Hit,
    input  logic       NearMiss,
    input  logic       Miss,
    input  logic [6:0] NumHits,
    input  logic       SomethingIsWrong,
    output logic       result_valid,
    output logic       result_hit,
    output logic       result_near,
    output logic       result_miss,
    output logic       result_err,
    output logic       result_repeat,
    output logic [6:0] shots_taken,
    output logic       game_over,
    output logic       game_won
);

    localparam logic [6:0] LP_MAX = 7'(MAX_SHOTS);
    localparam logic [6:0] LP_TOT = 7'(TOTAL_SHIP_CELLS);
    localparam logic [1:0] LP_BIG = 2'(BIG_SHOTS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_ISSUE  = 3'd2,
        S_RESULT = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_ready;
    logic        r_score;
    logic [3:0]  r_x;
    logic [3:0]  r_y;
    logic        r_big;
    logic [99:0] r_bitmap;
    logic [6:0]  r_shots;
    logic [1:0]  r_big_left;
    logic        r_over;
    logic        r_won;
    logic        r_res_valid;
    logic        r_res_hit;
    logic        r_res_near;
    logic        r_res_miss;
    logic        r_res_err;
    logic        r_res_rep;

    logic        w_xfer;
    logic        w_in_range;
    logic [6:0]  w_idx;
    logic        w_prev;
    logic        w_err;
    logic        w_win;
    logic        w_lost;
    logic        w_scored_ok;

    assign w_xfer      = shot_valid && r_ready;
    assign w_in_range  = (r_x <= 4'd9) && (r_y <= 4'd9);
    assign w_idx       = (7'(r_y) * 7'd10) + 7'(r_x);
    assign w_prev      = w_in_range ? r_bitmap[w_idx] : 1'b0;
    assign w_err       = !w_in_range || (r_big && (r_big_left == 2'd0));
    assign w_win       = (NumHits >= LP_TOT);
    assign w_lost      = (r_shots == LP_MAX);
    assign w_scored_ok = (r_state == S_ISSUE) && !SomethingIsWrong;

    // Next-state decode for the shot sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_next = S_CHECK;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CHECK: begin
                if (w_err || w_prev) begin
                    w_next = S_RESULT;
                end else begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE:  w_next = S_RESULT;
            S_RESULT: begin
                if (w_win || w_lost) begin
                    w_next = S_OVER;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_OVER:   w_next = S_OVER;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register, handshake, captured shot and score strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_score <= 1'b0;
            r_x     <= 4'd0;
            r_y     <= 4'd0;
            r_big   <= 1'b0;
        end else if (new_game) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_score <= 1'b0;
            r_x     <= 4'd0;
            r_y     <= 4'd0;
            r_big   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_IDLE);
            r_score <= (w_next == S_ISSUE);
            if (w_xfer) begin
                r_x   <= shot_x;
                r_y   <= shot_y;
                r_big <= shot_big;
            end
        end
    end

    // Game bookkeeping: history bitmap, shot count, big shots, end-of-game flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bitmap   <= 100'd0;
            r_shots    <= 7'd0;
            r_big_left <= LP_BIG;
            r_over     <= 1'b0;
            r_won      <= 1'b0;
        end else if (new_game) begin
            r_bitmap   <= 100'd0;
            r_shots    <= 7'd0;
            r_big_left <= LP_BIG;
            r_over     <= 1'b0;
            r_won      <= 1'b0;
        end else begin
            // Counters move on the ISSUE->RESULT edge so they are current while result_valid is high.
            if (w_scored_ok) begin
                r_bitmap[w_idx] <= 1'b1;
                if (r_shots < LP_MAX) begin
                    r_shots <= r_shots + 7'd1;
                end
                if (r_big && (r_big_left != 2'd0)) begin
                    r_big_left <= r_big_left - 2'd1;
                end
            end
            if ((r_state == S_RESULT) && (w_next == S_OVER)) begin
                r_over <= 1'b1;
                r_won  <= w_win;
            end
        end
    end

    // One-cycle result record, zero whenever result_valid is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_res_valid <= 1'b0;
            r_res_hit   <= 1'b0;
            r_res_near  <= 1'b0;
            r_res_miss  <= 1'b0;
            r_res_err   <= 1'b0;
            r_res_rep   <= 1'b0;
        end else if (new_game) begin
            r_res_valid <= 1'b0;
            r_res_hit   <= 1'b0;
            r_res_near  <= 1'b0;
            r_res_miss  <= 1'b0;
            r_res_err   <= 1'b0;
            r_res_rep   <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            r_res_hit   <= 1'b0;
            r_res_near  <= 1'b0;
            r_res_miss  <= 1'b0;
            r_res_err   <= 1'b0;
            r_res_rep   <= 1'b0;
            if (r_state == S_CHECK) begin
                if (w_err) begin
                    r_res_valid <= 1'b1;
                    r_res_err   <= 1'b1;
                end else if (w_prev) begin
                    r_res_valid <= 1'b1;
                    r_res_rep   <= 1'b1;
                end
            end else if (r_state == S_ISSUE) begin
                r_res_valid <= 1'b1;
                if (SomethingIsWrong) begin
                    r_res_err <= 1'b1;
                end else begin
                    r_res_hit  <= Hit;
                    r_res_near <= NearMiss;
                    r_res_miss <= Miss;
                end
            end
        end
    end

    assign shot_ready    = r_ready;
    assign X             = r_x;
    assign Y             = r_y;
    assign Big           = r_big;
    assign BigLeft       = r_big_left;
    assign ScoreThis     = r_score;
    assign result_valid  = r_res_valid;
    assign result_hit    = r_res_hit;
    assign result_near   = r_res_near;
    assign result_miss   = r_res_miss;
    assign result_err    = r_res_err;
    assign result_repeat = r_res_rep;
    assign shots_taken   = r_shots;
    assign game_over     = r_over;
    assign game_won      = r_won;

endmodule

// File: tb/tb_battleship_shot_ctrl.sv
// Bench for battleship_shot_ctrl: directed vector table, randomized shots against
// a game-level reference model, and reset/new_game corner sequences.
module tb_battleship_shot_ctrl;

    localparam int P_MAX = 2;
    localparam int P_TOT = 2;
    localparam int P_BIG = 1;

    localparam logic [4:0] R_HIT  = 5'b10000;
    localparam logic [4:0] R_NEAR = 5'b01000;
    localparam logic [4:0] R_MISS = 5'b00100;
    localparam logic [4:0] R_ERR  = 5'b00010;
    localparam logic [4:0] R_REP  = 5'b00001;

    localparam int RSP_HIT  = 0;
    localparam int RSP_NEAR = 1;
    localparam int RSP_MISS = 2;
    localparam int RSP_SIW  = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       new_game;
    logic       shot_valid;
    logic       shot_ready;
    logic [3:0] shot_x;
    logic [3:0] shot_y;
    logic       shot_big;
    logic [3:0] X;
    logic [3:0] Y;
    logic       Big;
    logic [1:0] BigLeft;
    logic       ScoreThis;
    logic       Hit;
    logic       NearMiss;
    logic       Miss;
    logic [6:0] NumHits;
    logic       SomethingIsWrong;
    logic       result_valid;
    logic       result_hit;
    logic       result_near;
    logic       result_miss;
    logic       result_err;
    logic       result_repeat;
    logic [6:0] shots_taken;
    logic       game_over;
    logic       game_won;

    int total = 0;
    int bad   = 0;
    int bb_hits = 0;

    assign NumHits = 7'(bb_hits);

    always #5 clock = ~clock;

    battleship_shot_ctrl #(
        .MAX_SHOTS       (P_MAX),
        .TOTAL_SHIP_CELLS(P_TOT),
        .BIG_SHOTS       (P_BIG)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .new_game        (new_game),
        .shot_valid      (shot_valid),
        .shot_ready      (shot_ready),
        .shot_x          (shot_x),
        .shot_y          (shot_y),
        .shot_big        (shot_big),
        .X               (X),
        .Y               (Y),
        .Big             (Big),
        .BigLeft         (BigLeft),
        .ScoreThis       (ScoreThis),
        .Hit             (Hit),
        .NearMiss        (NearMiss),
        .Miss            (Miss),
        .NumHits         (NumHits),
        .SomethingIsWrong(SomethingIsWrong),
        .result_valid    (result_valid),
        .result_hit      (result_hit),
        .result_near     (result_near),
        .result_miss     (result_miss),
        .result_err      (result_err),
        .result_repeat   (result_repeat),
        .shots_taken     (shots_taken),
        .game_over       (game_over),
        .game_won        (game_won)
    );

    typedef struct {
        bit         ng;
        logic [3:0] x;
        logic [3:0] y;
        logic       big;
        int         resp;
        logic [4:0] e_res;
        int         e_lat;
        int         e_sc;
        int         e_shots;
        int         e_bl;
        logic       e_over;
        logic       e_won;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        @(negedge clock);
        new_game = 1'b0;
        bb_hits  = 0;
    endtask

    // Issues one shot and plays Battleship; returns at the negedge one cycle after RESULT.
    task automatic run_shot(input logic [3:0] x, input logic [3:0] y, input logic big, input int resp,
                            output logic [4:0] res, output int lat, output int nsc,
                            output logic [3:0] sx, output logic [3:0] sy);
        bit done;
        res = 5'd0; lat = 0; nsc = 0; sx = 4'd0; sy = 4'd0; done = 1'b0;
        shot_x = x; shot_y = y; shot_big = big; shot_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (shot_ready) begin
                done = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!done) begin
            chk("xfer_timeout", 32'd0, 32'd1);
            shot_valid = 1'b0;
        end else begin
            @(posedge clock);
            for (int c = 1; c <= 8; c++) begin
                @(negedge clock);
                shot_valid = 1'b0;
                Hit = 1'b0; NearMiss = 1'b0; Miss = 1'b0; SomethingIsWrong = 1'b0;
                if (!result_valid) begin
                    chk("idle_result_zero",
                        {27'd0, result_hit, result_near, result_miss, result_err, result_repeat}, 32'd0);
                end
                if (ScoreThis) begin
                    nsc++;
                    sx = X; sy = Y;
                    Hit              = (resp == RSP_HIT);
                    NearMiss         = (resp == RSP_NEAR);
                    Miss             = (resp == RSP_MISS);
                    SomethingIsWrong = (resp == RSP_SIW);
                    if (resp == RSP_HIT) bb_hits++;
                end
                if (result_valid) begin
                    res = {result_hit, result_near, result_miss, result_err, result_repeat};
                    lat = c;
                    break;
                end
            end
            if (lat == 0) chk("result_timeout", 32'd0, 32'd1);
            @(negedge clock);
            if (ScoreThis) nsc++;
        end
    endtask

    logic [4:0] a_res;
    int         a_lat;
    int         a_sc;
    logic [3:0] a_sx;
    logic [3:0] a_sy;
    bit         hist[100];
    int         m_shots;
    int         m_bl;
    int         m_hits;

    initial begin
        reset = 1'b1; new_game = 1'b0; shot_valid = 1'b0; shot_x = 4'd0; shot_y = 4'd0;
        shot_big = 1'b0; Hit = 1'b0; NearMiss = 1'b0; Miss = 1'b0; SomethingIsWrong = 1'b0;

        //        ng x      y      big   resp      res     lat sc sh bl over  won
        tv[0] = '{1'b0, 4'd3,  4'd4,  1'b0, RSP_HIT,  R_HIT,  3, 1, 1, 1, 1'b0, 1'b0};
        tv[1] = '{1'b0, 4'd3,  4'd4,  1'b0, RSP_HIT,  R_REP,  2, 0, 1, 1, 1'b0, 1'b0};
        tv[2] = '{1'b0, 4'd10, 4'd2,  1'b0, RSP_HIT,  R_ERR,  2, 0, 1, 1, 1'b0, 1'b0};
        tv[3] = '{1'b0, 4'd2,  4'd10, 1'b1, RSP_HIT,  R_ERR,  2, 0, 1, 1, 1'b0, 1'b0};
        tv[4] = '{1'b0, 4'd5,  4'd5,  1'b0, RSP_SIW,  R_ERR,  3, 1, 1, 1, 1'b0, 1'b0};
        tv[5] = '{1'b0, 4'd5,  4'd5,  1'b0, RSP_HIT,  R_HIT,  3, 1, 2, 1, 1'b1, 1'b1};
        tv[6] = '{1'b1, 4'd3,  4'd4,  1'b1, RSP_MISS, R_MISS, 3, 1, 1, 0, 1'b0, 1'b0};
        tv[7] = '{1'b0, 4'd6,  4'd6,  1'b1, RSP_MISS, R_ERR,  2, 0, 1, 0, 1'b0, 1'b0};
        tv[8] = '{1'b0, 4'd3,  4'd4,  1'b0, RSP_MISS, R_REP,  2, 0, 1, 0, 1'b0, 1'b0};
        tv[9] = '{1'b0, 4'd9,  4'd9,  1'b0, RSP_NEAR, R_NEAR, 3, 1, 2, 0, 1'b1, 1'b0};

        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", shot_ready, 1);
        chk("rst_bigleft", BigLeft, P_BIG);
        chk("rst_outs", {X, Y, Big, ScoreThis, result_valid, shots_taken, game_over, game_won}, 0);

        for (int i = 0; i < 10; i++) begin
            if (tv[i].ng) begin
                pulse_new_game();
                chk("ng_clear", {shots_taken, game_over, game_won}, 0);
                chk("ng_ready", shot_ready, 1);
            end
            run_shot(tv[i].x, tv[i].y, tv[i].big, tv[i].resp, a_res, a_lat, a_sc, a_sx, a_sy);
            chk("vec_res", a_res, tv[i].e_res);
            chk("vec_lat", a_lat, tv[i].e_lat);
            chk("vec_score_cnt", a_sc, tv[i].e_sc);
            if (tv[i].e_sc == 1) chk("vec_xy", {a_sx, a_sy}, {tv[i].x, tv[i].y});
            chk("vec_shots", shots_taken, tv[i].e_shots);
            chk("vec_bigleft", BigLeft, tv[i].e_bl);
            chk("vec_over", game_over, tv[i].e_over);
            chk("vec_won", game_won, tv[i].e_won);
            chk("vec_ready", shot_ready, !tv[i].e_over);
        end

        // Randomized games against the reference model.
        pulse_new_game();
        foreach (hist[k]) hist[k] = 1'b0;
        m_shots = 0; m_bl = P_BIG; m_hits = 0;
        for (int n = 0; n < 300; n++) begin
            logic [3:0] rx, ry;
            logic       rb;
            int         rr, elat, esc;
            logic [4:0] eres;
            logic       eover, ewon;
            rx = 4'($urandom_range(0, 10));
            ry = 4'($urandom_range(0, 2));
            rb = ($urandom_range(0, 3) == 0);
            rr = $urandom_range(0, 3);
            if (rx > 9 || ry > 9 || (rb && m_bl == 0)) begin
                eres = R_ERR; elat = 2; esc = 0;
            end else if (hist[ry * 10 + rx]) begin
                eres = R_REP; elat = 2; esc = 0;
            end else begin
                elat = 3; esc = 1;
                if (rr == RSP_SIW) begin
                    eres = R_ERR;
                end else begin
                    eres = (rr == RSP_HIT) ? R_HIT : (rr == RSP_NEAR) ? R_NEAR : R_MISS;
                    hist[ry * 10 + rx] = 1'b1;
                    m_shots++;
                    if (rb) m_bl--;
                    if (rr == RSP_HIT) m_hits++;
                end
            end
            ewon  = (m_hits >= P_TOT);
            eover = ewon || (m_shots == P_MAX);
            run_shot(rx, ry, rb, rr, a_res, a_lat, a_sc, a_sx, a_sy);
            chk("rnd_res", a_res, eres);
            chk("rnd_lat", a_lat, elat);
            chk("rnd_score_cnt", a_sc, esc);
            chk("rnd_shots", shots_taken, m_shots);
            chk("rnd_bigleft", BigLeft, m_bl);
            chk("rnd_over", game_over, eover);
            chk("rnd_won", game_won, ewon);
            if (eover) begin
                pulse_new_game();
                foreach (hist[k]) hist[k] = 1'b0;
                m_shots = 0; m_bl = P_BIG; m_hits = 0;
            end
        end

        // new_game during ISSUE wins over the pending result.
        pulse_new_game();
        shot_x = 4'd1; shot_y = 4'd1; shot_big = 1'b0; shot_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        shot_valid = 1'b0;
        @(negedge clock);
        chk("ng_issue_strobe", ScoreThis, 1);
        new_game = 1'b1; Hit = 1'b1;
        @(negedge clock);
        new_game = 1'b0; Hit = 1'b0;
        chk("ng_issue_result", {result_valid, result_hit, ScoreThis}, 0);
        chk("ng_issue_shots", shots_taken, 0);
        chk("ng_issue_ready", shot_ready, 1);

        // Asynchronous reset during ISSUE clears outputs without a clock edge.
        shot_x = 4'd7; shot_y = 4'd8; shot_big = 1'b1; shot_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        shot_valid = 1'b0;
        @(negedge clock);
        chk("rst_issue_strobe", ScoreThis, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_outs", {X, Y, Big, ScoreThis, result_valid, shots_taken, game_over, game_won}, 0);
        chk("rst_async_bigleft", BigLeft, P_BIG);
        chk("rst_async_ready", shot_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
